// File: rtl/mat4_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : mat4_result_streamer
//  Description : Captures one packed 4x4 matrix and replays it one element per
//                beat as a tagged valid/ready stream (row- or column-major).
//  Revision    : 1.0 - initial release
// ============================================================================
module mat4_result_streamer #(
  parameter int ELEM_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [16*ELEM_W-1:0]  in_mat,
  input  logic                  in_colmaj,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ELEM_W-1:0]     out_data,
  output logic [1:0]            out_row,
  output logic [1:0]            out_col,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [7:0]            mat_count
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [16*ELEM_W-1:0]   r_mat;
  logic                   r_colmaj;
  logic [3:0]             r_idx;
  logic [7:0]             r_count;

  logic [ELEM_W-1:0]      w_elems [16];
  logic [1:0]             w_row;
  logic [1:0]             w_col;
  logic                   w_last;
  logic                   w_xfer;
  logic                   w_accept;

  // Element [i][j] sits at flat position 4i+j, counted from the MSB end.
  generate
    for (genvar e = 0; e < 16; e++) begin : g_unpack
      assign w_elems[e] = r_mat[16*ELEM_W-1-ELEM_W*e -: ELEM_W];
    end
  endgenerate

  assign w_row     = r_colmaj ? r_idx[1:0] : r_idx[3:2];
  assign w_col     = r_colmaj ? r_idx[3:2] : r_idx[1:0];
  assign w_last    = (r_idx == 4'd15);

  assign out_valid = (r_state == ST_STREAM);
  assign out_data  = w_elems[{w_row, w_col}];
  assign out_row   = w_row;
  assign out_col   = w_col;
  assign out_last  = out_valid & w_last;
  assign busy      = (r_state == ST_STREAM);
  assign mat_count = r_count;

  // out_ready reaches in_ready combinationally so a new matrix can follow the
  // final beat without a bubble.
  assign w_xfer    = out_valid & out_ready;
  assign in_ready  = (r_state == ST_IDLE) | (w_xfer & w_last);
  assign w_accept  = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (w_xfer && w_last && !w_accept) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mat    <= '0;
      r_colmaj <= 1'b0;
      r_idx    <= 4'd0;
      r_count  <= 8'd0;
    end else begin
      if (w_accept) begin
        r_mat    <= in_mat;
        r_colmaj <= in_colmaj;
        r_idx    <= 4'd0;
      end else if (w_xfer) begin
        r_idx    <= r_idx + 4'd1;
      end
      if (w_xfer && w_last) begin
        r_count  <= r_count + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire
